// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with freeze, flush/bubble squash.
// Define ID_EXE_FWD_EN to register src1/src2 for the forwarding unit.
module id_exe_stage_reg #(
    parameter int WORD  = 32,
    parameter int RADDR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             cond_pass,
    input  logic             b_in,
    input  logic [3:0]       exe_cmd_in,
    input  logic             s_in,
    input  logic             wb_en_in,
    input  logic             mem_r_in,
    input  logic             mem_w_in,
    input  logic             ret_in,
    input  logic [WORD-1:0]  pc_in,
    input  logic [WORD-1:0]  val_rn_in,
    input  logic [WORD-1:0]  val_rm_in,
    input  logic             imm_in,
    input  logic [11:0]      shift_op_in,
    input  logic [23:0]      simm24_in,
    input  logic [RADDR-1:0] dest_in,
    input  logic [RADDR-1:0] src1_in,
    input  logic [RADDR-1:0] src2_in,
    input  logic             carry_in,
    output logic             valid_out,
    output logic             b_out,
    output logic [3:0]       exe_cmd_out,
    output logic             s_out,
    output logic             wb_en_out,
    output logic             mem_r_out,
    output logic             mem_w_out,
    output logic             ret_out,
    output logic [WORD-1:0]  pc_out,
    output logic [WORD-1:0]  val_rn_out,
    output logic [WORD-1:0]  val_rm_out,
    output logic             imm_out,
    output logic [11:0]      shift_op_out,
    output logic [23:0]      simm24_out,
    output logic [RADDR-1:0] dest_out,
    output logic             carry_out,
    output logic [RADDR-1:0] src1_out,
    output logic [RADDR-1:0] src2_out
);
    logic             r_valid;
    logic [9:0]       r_ctrl;
    logic [WORD-1:0]  r_pc;
    logic [WORD-1:0]  r_rn;
    logic [WORD-1:0]  r_rm;
    logic             r_imm;
    logic [11:0]      r_shift;
    logic [23:0]      r_simm;
    logic [RADDR-1:0] r_dest;
    logic             r_carry;
    logic             w_kill;

    assign w_kill = flush | hazard | ~cond_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_imm   <= 1'b0;
            r_shift <= '0;
            r_simm  <= '0;
            r_dest  <= '0;
            r_carry <= 1'b0;
        end else if (!freeze) begin
            r_valid <= ~w_kill;
            r_ctrl  <= w_kill ? '0 : {b_in, exe_cmd_in, s_in, wb_en_in, mem_r_in, mem_w_in, ret_in};
            r_pc    <= pc_in;
            r_rn    <= val_rn_in;
            r_rm    <= val_rm_in;
            r_imm   <= imm_in;
            r_shift <= shift_op_in;
            r_simm  <= simm24_in;
            r_dest  <= dest_in;
            r_carry <= carry_in;
        end
    end

`ifdef ID_EXE_FWD_EN
    logic [RADDR-1:0] r_src1;
    logic [RADDR-1:0] r_src2;

    // Cleared on a bubble so a squashed slot never aliases an R0 match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (!freeze) begin
            r_src1 <= w_kill ? '0 : src1_in;
            r_src2 <= w_kill ? '0 : src2_in;
        end
    end

    assign src1_out = r_src1;
    assign src2_out = r_src2;
`else
    logic w_unused_src;

    assign w_unused_src = ^{src1_in, src2_in};
    assign src1_out     = '0;
    assign src2_out     = '0;
`endif

    assign valid_out    = r_valid;
    assign {b_out, exe_cmd_out, s_out, wb_en_out, mem_r_out, mem_w_out, ret_out} = r_ctrl;
    assign pc_out       = r_pc;
    assign val_rn_out   = r_rn;
    assign val_rm_out   = r_rm;
    assign imm_out      = r_imm;
    assign shift_op_out = r_shift;
    assign simm24_out   = r_simm;
    assign dest_out     = r_dest;
    assign carry_out    = r_carry;
endmodule

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

Pipeline register between the decode stage (control unit, register file, condition check) and the execute stage. Captures the decoded control bundle and operand data once per cycle and presents it registered to the ALU, branch adder and memory stage. It also performs bubble insertion for hazards and failed conditions, flushing on a taken branch, and freezing on memory stalls.

## Interface
- `WORD`, 32, data/PC width
- `RADDR`, 4, register address width
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `freeze` in 1: hold all state (memory stall)
- `flush` in 1: taken branch resolved in EXE; squash the entry being captured
- `hazard` in 1: data hazard from the hazard unit; insert a bubble
- `cond_pass` in 1: condition-check result for the decoding instruction
- `b_in` in 1: control bundle from the control unit
- `exe_cmd_in` in 4: control bundle from the control unit
- `s_in` in 1: control bundle from the control unit
- `wb_en_in` in 1: control bundle from the control unit
- `mem_r_in` in 1: control bundle from the control unit
- `mem_w_in` in 1: control bundle from the control unit
- `ret_in` in 1: control bundle from the control unit
- `pc_in` in WORD: PC+4 of the decoding instruction
- `val_rn_in` in WORD: register-file read data
- `val_rm_in` in WORD: register-file read data
- `imm_in` in 1: immediate flag
- `shift_op_in` in 12: shifter operand field
- `simm24_in` in 24: branch offset
- `dest_in` in RADDR: destination register
- `src1_in` in RADDR: source register addresses
- `src2_in` in RADDR: source register addresses
- `carry_in` in 1: C flag from the status register
- `valid_out` out 1: EXE holds a real instruction
- `b_out` out 1: registered control, qualified as described below
- `exe_cmd_out` out 4: registered control, qualified as described below
- `s_out` out 1: registered control, qualified as described below
- `wb_en_out` out 1: registered control, qualified as described below
- `mem_r_out` out 1: registered control, qualified as described below
- `mem_w_out` out 1: registered control, qualified as described below
- `ret_out` out 1: registered control, qualified as described below
- `pc_out` out WORD: registered data
- `val_rn_out` out WORD: registered data
- `val_rm_out` out WORD: registered data
- `imm_out` out 1: registered data
- `shift_op_out` out 12: registered data
- `simm24_out` out 24: registered data
- `dest_out` out RADDR: registered data
- `carry_out` out 1: registered data
- `src1_out` out RADDR: present only with `ID_EXE_FWD_EN`
- `src2_out` out RADDR: present only with `ID_EXE_FWD_EN`

## Operation
- Per-edge action, first matching rule wins:
  1. `rst_n` low: all outputs 0, asynchronously.
  2. `freeze`: hold every register. This includes flush and hazard; the EXE branch re-asserts flush after the freeze.
  3. `flush`: **squash** — `valid_out`=0 and all seven control outputs 0. Data registers load normally (don't-care).
  4. `hazard` or `!cond_pass`: **bubble** — identical to squash.
  5. Otherwise: **load** — all inputs captured and `valid_out`=1.
- Any control output of 1 implies `valid_out`=1. This invariant holds in every cycle.
- A bubble never writes memory, the register file or flags (`s_out`=0).
- Opcode `exe_cmd_in` is passed through unmodified; no decoding happens here.
- `ret_out` is treated exactly like `b_out` for squash and bubble.

## Timing
- Latency: 1 cycle from input to output. No combinational path from any input to any output.
- Reset: asynchronous assert, synchronous release on the first `clk` rising edge after `rst_n` rises. After reset, outputs read as a bubble.
- `freeze` held N cycles: outputs stable for N cycles. The first edge after deassertion applies rules 3–5 to the inputs present at that edge.
- `flush` and `hazard` together: squash (same result).
- `rst_n` asserted mid-freeze: registers clear immediately. They stay clear until release regardless of `freeze`.

## Configuration
- `ID_EXE_FWD_EN` defined:
  - `src1_in` and `src2_in` are registered with the data.
  - They are exported as `src1_out` and `src2_out` for the forwarding unit.
  - On squash or bubble they are forced to 0, so a bubble never matches R0 forwarding; the forwarding unit also gates matches with `valid_out`.
- Not defined:
  - The ports still exist.
  - `src1_out` and `src2_out` are tied to 0.
  - No registers are inferred for them.

## Test plan
- **Load:** with `rst_n` released, drive ADD (`exe_cmd_in`=EXE_ADD, `wb_en_in`=1, `val_rn_in`=0x10, `val_rm_in`=0x20, `dest_in`=3, `cond_pass`=1). Required next cycle: `valid_out`=1, `wb_en_out`=1, `val_rn_out`=0x10, `dest_out`=3.
- **Condition fail:** same stimulus with `cond_pass`=0. Required next cycle: `valid_out`=0 and all control outputs 0.
- **Freeze:** load an STR (`mem_w_in`=1), then `freeze`=1 for 3 cycles while the inputs change to MOV. Required: `mem_w_out`=1 and all data unchanged for 3 cycles; MOV appears one cycle after `freeze` drops.
- **Freeze over flush:** `freeze`=1 and `flush`=1 together. Required: outputs held. Then `freeze`=0 with `flush`=1. Required: squash next cycle.
- **Async reset:** drop `rst_n` mid-cycle with a valid B (`b_out`=1) in the register. Required: `b_out`=0 and `valid_out`=0 before the next edge; outputs stay 0 while `freeze`=1 at release.
- **Forwarding (with `ID_EXE_FWD_EN`):** `src1_in`=5, `src2_in`=7, normal load. Required: `src1_out`=5, `src2_out`=7. Then `hazard`=1. Required: `src1_out`=0, `src2_out`=0.
